// File: rtl/nreg_file.sv
// Register file with one write port, two registered read ports and a sweeping clear.
// A clear request zeroes one entry per cycle in ascending order while io_busy is high.
module nreg_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       io_wen,
  input  logic [$clog2(DEPTH)-1:0]   io_waddr,
  input  logic [WIDTH-1:0]           io_wdata,
  input  logic                       io_ren_0,
  input  logic                       io_ren_1,
  input  logic [$clog2(DEPTH)-1:0]   io_raddr_0,
  input  logic [$clog2(DEPTH)-1:0]   io_raddr_1,
  output logic [WIDTH-1:0]           io_rdata_0,
  output logic [WIDTH-1:0]           io_rdata_1,
  output logic                       io_rvalid_0,
  output logic                       io_rvalid_1,
  input  logic                       io_clear,
  output logic                       io_busy,
  output logic                       dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Handshake: there is no backpressure. A read request is accepted in any
  // IDLE cycle; its data appears with rvalid high on the following cycle only.
  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rdata_0_q, rdata_0_d;
  logic [WIDTH-1:0]  rdata_1_q, rdata_1_d;
  logic              rvalid_0_q, rvalid_0_d;
  logic              rvalid_1_q, rvalid_1_d;

  logic              in_idle;
  logic              wr_fire;
  logic              byp_0;
  logic              byp_1;

  assign in_idle = (state_q == ST_IDLE);
  // Clear wins over a simultaneous write, so the write only fires without it.
  assign wr_fire = in_idle && io_wen && !io_clear;
  assign byp_0   = wr_fire && (io_waddr == io_raddr_0);
  assign byp_1   = wr_fire && (io_waddr == io_raddr_1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rdata_0_d  = rdata_0_q;
    rdata_1_d  = rdata_1_q;
    rvalid_0_d = 1'b0;
    rvalid_1_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Reads in the clear-accepting cycle still see pre-clear contents.
        if (io_ren_0) begin
          rvalid_0_d = 1'b1;
          rdata_0_d  = byp_0 ? io_wdata : mem_q[io_raddr_0];
        end
        if (io_ren_1) begin
          rvalid_1_d = 1'b1;
          rdata_1_d  = byp_1 ? io_wdata : mem_q[io_raddr_1];
        end
        if (io_clear) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      rdata_0_q  <= '0;
      rdata_1_q  <= '0;
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rdata_0_q  <= rdata_0_d;
      rdata_1_q  <= rdata_1_d;
      rvalid_0_q <= rvalid_0_d;
      rvalid_1_q <= rvalid_1_d;
      if (wr_fire) begin
        mem_q[io_waddr] <= io_wdata;
      end
      if (state_q == ST_CLEAR) begin
        mem_q[ptr_q] <= '0;
      end
    end
  end

  assign io_rdata_0  = rdata_0_q;
  assign io_rdata_1  = rdata_1_q;
  assign io_rvalid_0 = rvalid_0_q;
  assign io_rvalid_1 = rvalid_1_q;
  assign io_busy     = (state_q == ST_CLEAR);
  assign dbg_state_o = state_q;

endmodule

// File: doc/nreg_file.md
NREG_FILE -- requirements
Module: nreg_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of stored words; it is a power of two and DEPTH >= 2.
REQ-003 The block SHALL derive AW = log2(DEPTH) as the address width; AW is not a user parameter.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port io_wen, input, 1 bit, write request.
REQ-008 The block SHALL have port io_waddr, input, AW bits, write address.
REQ-009 The block SHALL have port io_wdata, input, WIDTH bits, write data.
REQ-010 The block SHALL have ports io_ren_0 and io_ren_1, input, 1 bit each, read request for read port 0 and read port 1.
REQ-011 The block SHALL have ports io_raddr_0 and io_raddr_1, input, AW bits each, read address for port 0 and port 1.
REQ-012 The block SHALL have ports io_rdata_0 and io_rdata_1, output, WIDTH bits each, registered read data.
REQ-013 The block SHALL have ports io_rvalid_0 and io_rvalid_1, output, 1 bit each, read data valid.
REQ-014 The block SHALL have port io_clear, input, 1 bit, request to zero all entries.
REQ-015 The block SHALL have port io_busy, output, 1 bit, high while a clear sweep is in progress.

Function
REQ-016 The block SHALL store DEPTH independent words of WIDTH bits each.
REQ-017 The block SHALL use a two-state FSM: IDLE and CLEAR.
REQ-018 In IDLE with io_wen=1 and io_clear=0, the block SHALL write io_wdata to entry io_waddr at the clock edge.
REQ-019 The block SHALL ignore io_wen while in CLEAR; no entry is modified by the write port.
REQ-020 Read port p with io_ren_p=1 in IDLE at cycle N SHALL give io_rdata_p = entry(io_raddr_p) and io_rvalid_p=1 in cycle N+1 (1-cycle latency).
REQ-021 io_rvalid_p SHALL be 1 for exactly one cycle per accepted read and 0 otherwise.
REQ-022 When io_rvalid_p=0, io_rdata_p SHALL hold its last value.
REQ-023 For a write and a read to the same address in the same IDLE cycle, the read SHALL return the new io_wdata (write-first bypass), independently on each port.
REQ-024 Both read ports SHALL operate concurrently, including reads of the same address.
REQ-025 Read requests while in CLEAR SHALL be ignored: io_rvalid_p=0 and io_rdata_p held.
REQ-026 io_clear=1 in IDLE SHALL move the FSM to CLEAR at that edge and reset the sweep pointer to 0.
REQ-027 In CLEAR, the block SHALL zero one entry per cycle at the sweep pointer, in ascending order 0..DEPTH-1, then return to IDLE.
REQ-028 io_busy SHALL be 1 for exactly DEPTH consecutive cycles, starting the cycle after io_clear is sampled in IDLE.
REQ-029 io_clear and io_wen together in IDLE SHALL give clear priority; the write is dropped.
REQ-030 Reads presented in the same cycle as an accepted io_clear SHALL be accepted and SHALL return pre-clear contents.
REQ-031 io_clear asserted while in CLEAR SHALL be ignored; the sweep neither restarts nor extends.
REQ-032 A read issued the cycle after io_busy falls SHALL return 0 for every address not written since.

Reset
REQ-033 reset=1 at a clock edge SHALL set all DEPTH entries to 0, the FSM to IDLE, the sweep pointer to 0, io_busy=0, io_rvalid_0=io_rvalid_1=0 and io_rdata_0=io_rdata_1=0.
REQ-034 reset SHALL take priority over io_wen, io_ren_p and io_clear in the same cycle.
REQ-035 reset asserted during CLEAR SHALL abort the sweep, with the state given in REQ-033, on the next edge.

Verification
REQ-036 The bench SHALL cover write-then-read: with WIDTH=8, DEPTH=4, write 0xA5@1 then 0x3C@2, then read port0@1 and port1@2 in one cycle -> the next cycle has rdata_0=0xA5, rdata_1=0x3C and both rvalid=1 for one cycle only.
REQ-037 The bench SHALL cover bypass: write 0x77@3 with ren_0=1, raddr_0=3 in the same cycle -> the next cycle has rdata_0=0x77 and rvalid_0=1.
REQ-038 The bench SHALL cover a clear sweep: fill all entries with 0xFF, then pulse io_clear -> busy=1 for exactly 4 cycles; writes and reads during busy are ignored (rvalid=0); afterwards reads of entries 0..3 return 0x00.
REQ-039 The bench SHALL cover clear/write collision: io_clear and io_wen (0x11@0) in the same IDLE cycle -> after the sweep, entry 0 reads 0x00.
REQ-040 The bench SHALL cover reset mid-clear: assert reset during the 2nd busy cycle -> the next cycle has busy=0, rvalid=0 and rdata=0, and all entries read 0x00.
REQ-041 The bench SHALL cover parameter scaling: with WIDTH=16, DEPTH=8, write 0xBEEF@7 and read it on both ports -> both return 0xBEEF, and busy lasts exactly 8 cycles on clear.
